// File: rtl/wb_queue_pkg.sv
// rtl/wb_queue_pkg.sv - write-result record layout and queue sizing constants shared by wb_queue
package wb_queue_pkg;

    localparam int WB_WE_W   = 1;
    localparam int WB_ADDR_W = 5;
    localparam int WB_DATA_W = 32;

    localparam int REG_WRITE_RESULT_BUS_LENGTH = WB_WE_W + WB_ADDR_W + WB_DATA_W;

    localparam int WB_LANES = 2;
    localparam int WB_DEPTH = 4;

    typedef struct packed {
        logic                 we;
        logic [WB_ADDR_W-1:0] addr;
        logic [WB_DATA_W-1:0] data;
    } wb_result_t;

    function automatic int wb_ptr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/wb_queue_mem.sv
// rtl/wb_queue_mem.sv - DEPTH x WIDTH register array, one write port, one async read port
module wb_queue_mem
    import wb_queue_pkg::*;
#(
    parameter int DEPTH = WB_DEPTH,
    parameter int WIDTH = WB_LANES * REG_WRITE_RESULT_BUS_LENGTH
) (
    input  logic                       i_clk,
    input  logic                       i_we,
    input  logic [wb_ptr_w(DEPTH)-1:0] i_waddr,
    input  logic [WIDTH-1:0]           i_wdata,
    input  logic [wb_ptr_w(DEPTH)-1:0] i_raddr,
    output logic [WIDTH-1:0]           o_rdata
);

    logic [WIDTH-1:0] r_mem [DEPTH];

    // Contents are never reset; the queue gates the read data when empty.
    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/wb_queue.sv
// rtl/wb_queue.sv - in-order writeback result queue; optional same-cycle bypass under WB_QUEUE_BYPASS_EN
module wb_queue
    import wb_queue_pkg::*;
#(
    parameter int DATA_W = REG_WRITE_RESULT_BUS_LENGTH,
    parameter int LANES  = WB_LANES,
    parameter int DEPTH  = WB_DEPTH
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [LANES*DATA_W-1:0]    in_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [LANES*DATA_W-1:0]    out_data,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int W  = LANES * DATA_W;
    localparam int PW = wb_ptr_w(DEPTH);
    localparam int CW = $clog2(DEPTH) + 1;

    logic [PW-1:0] r_wptr;
    logic [PW-1:0] r_rptr;
    logic [CW-1:0] r_count;

    logic          w_stored_valid;
    logic          w_bypass;
    logic          w_push;
    logic          w_pop;
    logic [W-1:0]  w_rdata;

    assign w_stored_valid = (r_count != '0);

`ifdef WB_QUEUE_BYPASS_EN
    assign w_bypass = (r_count == '0) && in_valid && !flush;
`else
    assign w_bypass = 1'b0;
`endif

    assign in_ready  = (r_count < CW'(DEPTH));
    assign out_valid = w_stored_valid || w_bypass;
    assign out_data  = w_bypass       ? in_data :
                       w_stored_valid ? w_rdata : '0;
    assign count     = r_count;

    // A bypassed entry taken by the consumer in the same cycle never touches storage.
    assign w_push = in_valid && in_ready && !flush && !(w_bypass && out_ready);
    assign w_pop  = w_stored_valid && out_ready && !flush;

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + PW'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + PW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    wb_queue_mem #(
        .DEPTH (DEPTH),
        .WIDTH (W)
    ) u_mem (
        .i_clk   (clk),
        .i_we    (w_push),
        .i_waddr (r_wptr),
        .i_wdata (in_data),
        .i_raddr (r_rptr),
        .o_rdata (w_rdata)
    );

endmodule

// File: doc/wb_queue.md
WB_QUEUE -- requirements
Module: wb_queue

Interface
REQ-001 SHALL have parameter DATA_W, default 38, width of one lane's write-result record (we, addr, data).
REQ-002 SHALL have parameter LANES, default 2, number of parallel write-result lanes carried per entry.
REQ-003 SHALL have parameter DEPTH, default 4, power of two >= 2, number of buffered entries.
REQ-004 SHALL have port clk  in  1  sole clock; all state updates on posedge.
REQ-005 SHALL have port rst  in  1  synchronous, active-high reset.
REQ-006 SHALL have port flush  in  1  discards all buffered and incoming entries.
REQ-007 SHALL have port in_valid  in  1  producer offers an entry.
REQ-008 SHALL have port in_ready  out  1  queue accepts an entry this cycle.
REQ-009 SHALL have port in_data  in  LANES*DATA_W  lane i occupies bits [i*DATA_W +: DATA_W].
REQ-010 SHALL have port out_valid  out  1  head entry presented.
REQ-011 SHALL have port out_ready  in  1  consumer (register file) takes the head entry.
REQ-012 SHALL have port out_data  out  LANES*DATA_W  head entry; all-zero when out_valid=0.
REQ-013 SHALL have port count  out  $clog2(DEPTH)+1  current occupancy.

Function
REQ-014 Push SHALL occur on an edge where in_valid && in_ready && !flush; pop SHALL occur on an edge where out_valid && out_ready && !flush.
REQ-015 in_ready SHALL equal (count < DEPTH); it SHALL NOT depend on out_ready.
REQ-016 Entries SHALL leave in arrival order; read and write pointers SHALL wrap modulo DEPTH.
REQ-017 Push and pop on the same edge SHALL leave count unchanged, including at count==DEPTH-1 and count==1.
REQ-018 Latency without bypass SHALL be one cycle: entry pushed at edge N is on out_data with out_valid=1 from edge N until popped.
REQ-019 out_valid SHALL equal (count != 0) without bypass; out_data SHALL be forced to zero whenever out_valid=0, so an idle writeback never asserts a register write.
REQ-020 flush SHALL win over every simultaneous push and pop: next edge count=0, pointers=0, out_valid=0; the flushed-cycle input is dropped.
REQ-021 count SHALL never exceed DEPTH nor underflow; a pop attempt when empty is impossible because out_valid=0.

Reset
REQ-022 On rst at posedge: count=0, pointers=0, out_valid=0, out_data=0, in_ready=1 on the following cycle.
REQ-023 rst SHALL dominate flush and any handshake; an entry in flight mid-reset is lost.
REQ-024 Storage array contents need not be cleared; out_data gating per REQ-019 hides them.

Configuration
REQ-025 Macro WB_QUEUE_BYPASS_EN, when defined, SHALL add a combinational path: when count==0 and in_valid && !flush, out_valid=1 and out_data=in_data in the same cycle; if out_ready is also 1 the entry SHALL NOT be written to storage and count stays 0.
REQ-026 Without WB_QUEUE_BYPASS_EN, no combinational path from in_* to out_* SHALL exist.

Structure
REQ-027 DATA_W field layout (we bit, addr width, data width) and REG_WRITE_RESULT_BUS_LENGTH-derived constants SHALL live in the shared config header; no local redefinition.
REQ-028 Storage SHALL be one sub-module wb_queue_mem (DEPTH x LANES*DATA_W register array, one write port, one async read port); pointer/count control stays in wb_queue.

Verification
REQ-029 Reset then idle: rst=1 one cycle -> count=0, out_valid=0, out_data=0, in_ready=1.
REQ-030 Fill: out_ready=0, push entries A..D (DEPTH=4) -> count=4, in_ready=0, out_data=A; fifth in_valid not accepted.
REQ-031 Stream: in_valid=out_ready=1 for 10 cycles with incrementing data -> outputs in order, count steady at 1 (0 with bypass), no loss.
REQ-032 Flush: count=3, assert flush with in_valid=1 and out_ready=1 -> next cycle count=0, out_valid=0, out_data=0, none of the four entries appears later.
REQ-033 Wrap: 9 push/pop pairs with count oscillating 0..3 -> pointers wrap twice, order preserved, count matches a reference model every cycle.
REQ-034 Bypass (macro defined): empty queue, in_valid=1, in_data=0x5A, out_ready=1 -> out_valid=1 and out_data=0x5A same cycle, count stays 0; macro undefined -> out_valid rises one edge later.
